// File: rtl/seq_shift_add_mult_if.sv
// Request/result bundle for the sequential shift-and-add multiplier.
// The requester drives the operands and start; the multiplier returns the product and status.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [2*WIDTH-1:0]     p;
  logic                   ready;
  logic                   done;

  modport master (
    output start, signed_mode, a, b,
    input  p, ready, done
  );

  modport slave (
    input  start, signed_mode, a, b,
    output p, ready, done
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier with a per-operation signed/unsigned mode.
// It performs one partial-product step per clock, holds the product in a register and pulses done on completion.
module seq_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input logic                 ck,
  input logic                 rst,
  seq_shift_add_mult_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [WIDTH-1:0]        ax;
  logic [WIDTH-1:0]        mr;
  logic [WIDTH:0]          acc;
  logic                    mode;
  logic [2*WIDTH-1:0]      p_q;
  logic                    done_q;

  logic                    last_step;
  logic [WIDTH:0]          term;
  logic signed [WIDTH+1:0] accx;
  logic signed [WIDTH+1:0] tx;
  logic signed [WIDTH+1:0] sum;
  logic [WIDTH:0]          acc_nx;
  logic [WIDTH-1:0]        mr_nx;

  // Extend a guard-bit value by one more bit so the unsigned carry or signed result never overflows.
  function automatic logic signed [WIDTH+1:0] widen(input logic [WIDTH:0] v, input logic sgn);
    widen = sgn ? {v[WIDTH], v} : {1'b0, v};
  endfunction

  always_comb begin
    last_step = (cnt == CNT_W'(WIDTH - 1));
    term      = mode ? {ax[WIDTH-1], ax} : {1'b0, ax};
    accx      = widen(acc, mode);
    tx        = widen(term, mode);
    sum       = accx;
    if (mr[0]) begin
      // In signed mode the multiplier's sign bit carries negative weight.
      sum = (mode && last_step) ? (accx - tx) : (accx + tx);
    end
    // Shifting the extended sum yields an arithmetic shift in signed mode and brings the carry in otherwise.
    acc_nx = sum[WIDTH+1:1];
    mr_nx  = {sum[0], mr[WIDTH-1:1]};
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ax     <= '0;
      mr     <= '0;
      acc    <= '0;
      mode   <= 1'b0;
      p_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_RUN;
            ax    <= bus.a;
            mr    <= bus.b;
            acc   <= '0;
            cnt   <= '0;
            mode  <= bus.signed_mode;
          end
        end
        S_RUN: begin
          acc <= acc_nx;
          mr  <= mr_nx;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            state  <= S_IDLE;
            p_q    <= {acc_nx[WIDTH-1:0], mr_nx};
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.p     = p_q;
  assign bus.ready = (state == S_IDLE);
  assign bus.done  = done_q;

endmodule
